// File: rtl/rv_pkg.sv
// ============================================================================
// Module : rv_pkg
// Brief  : RV32I opcode constants and run-sequencer state type.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYS    = 7'b1110011;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    LOADED = 3'd2,
    RUN    = 3'd3,
    HALT   = 3'd4
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/seq_watchdog.sv
// ============================================================================
// Module : seq_watchdog
// Brief  : Saturating released-cycle counter with watchdog limit flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_watchdog #(
  parameter int MAX_CYCLES = 100000,
  parameter int CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             limit_o
);

  localparam logic [63:0]      C_LIMIT = 64'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] C_SAT   = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != C_SAT)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Compared at 64 bits so a limit beyond the counter range simply never fires.
  assign limit_o = (64'(count_q) >= C_LIMIT);
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/cpu_run_sequencer.sv
// ============================================================================
// Module : cpu_run_sequencer
// Brief  : Loads a program image into imem, runs the core, detects halt.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cpu_run_sequencer
  import rv_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int MAX_CYCLES = 100000,
  parameter int CNT_W      = 32
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          load_valid_i,
  output logic                          load_ready_o,
  input  logic [31:0]                   load_data_i,
  input  logic                          load_last_i,
  input  logic                          run_i,
  input  logic                          clear_i,
  output logic                          imem_we_o,
  output logic [$clog2(IMEM_WORDS)-1:0] imem_waddr_o,
  output logic [31:0]                   imem_wdata_o,
  output logic                          cpu_resetn_o,
  input  logic [31:0]                   cpu_instr_i,
  input  logic [31:0]                   cpu_pc_i,
  output logic                          halted_o,
  output logic                          timeout_o,
  output logic                          load_trunc_o,
  output logic [31:0]                   halt_pc_o,
  output logic [CNT_W-1:0]              cycle_count_o
);

  localparam int           AW         = $clog2(IMEM_WORDS);
  localparam logic [AW-1:0] C_LAST_IDX = AW'(IMEM_WORDS - 1);

  seq_state_t  state_q, state_d;
  logic        load_ready_q, load_ready_d;
  logic [AW-1:0] idx_q, idx_d;
  logic        we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resetn_q, resetn_d;
  logic        halted_q, halted_d;
  logic        timeout_q, timeout_d;
  logic        trunc_q, trunc_d;
  logic [31:0] halt_pc_q, halt_pc_d;

  logic w_accept;
  logic w_sys;
  logic w_clear;
  logic w_cnt_inc;
  logic w_cnt_rst;
  logic w_limit;
  logic w_unused_instr;

  assign w_accept  = (state_q == LOAD) && load_valid_i && load_ready_q;
  assign w_sys     = resetn_q && (cpu_instr_i[6:0] == OPC_SYS);
  assign w_clear   = (state_q == HALT) && clear_i;
  assign w_cnt_inc = (state_q == RUN) && resetn_q && !w_sys && !w_limit;
  assign w_cnt_rst = reset_i || w_clear;

  assign w_unused_instr = ^cpu_instr_i[31:7];

  seq_watchdog #(
    .MAX_CYCLES (MAX_CYCLES),
    .CNT_W      (CNT_W)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_i   (w_cnt_rst),
    .inc_i   (w_cnt_inc),
    .count_o (cycle_count_o),
    .limit_o (w_limit)
  );

  always_comb begin
    state_d      = state_q;
    load_ready_d = load_ready_q;
    idx_d        = idx_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    resetn_d     = resetn_q;
    halted_d     = halted_q;
    timeout_d    = timeout_q;
    trunc_d      = trunc_q;
    halt_pc_d    = halt_pc_q;

    case (state_q)
      IDLE: begin
        state_d      = LOAD;
        load_ready_d = 1'b1;
      end
      LOAD: begin
        if (w_accept) begin
          we_d    = 1'b1;
          waddr_d = idx_q;
          wdata_d = load_data_i;
          // The index is frozen on the final word so it can never wrap.
          if (load_last_i || (idx_q == C_LAST_IDX)) begin
            state_d      = LOADED;
            load_ready_d = 1'b0;
            trunc_d      = !load_last_i;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      LOADED: begin
        if (run_i) begin
          state_d  = RUN;
          resetn_d = 1'b1;
        end
      end
      RUN: begin
        if (w_sys) begin
          state_d   = HALT;
          halted_d  = 1'b1;
          halt_pc_d = cpu_pc_i;
        end else if (w_limit) begin
          state_d   = HALT;
          halted_d  = 1'b1;
          timeout_d = 1'b1;
          halt_pc_d = cpu_pc_i;
          resetn_d  = 1'b0;
        end
      end
      HALT: begin
        if (clear_i) begin
          state_d      = IDLE;
          load_ready_d = 1'b0;
          idx_d        = '0;
          waddr_d      = '0;
          wdata_d      = '0;
          resetn_d     = 1'b0;
          halted_d     = 1'b0;
          timeout_d    = 1'b0;
          trunc_d      = 1'b0;
          halt_pc_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      load_ready_q <= 1'b0;
      idx_q        <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      resetn_q     <= 1'b0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
      trunc_q      <= 1'b0;
      halt_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      load_ready_q <= load_ready_d;
      idx_q        <= idx_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      resetn_q     <= resetn_d;
      halted_q     <= halted_d;
      timeout_q    <= timeout_d;
      trunc_q      <= trunc_d;
      halt_pc_q    <= halt_pc_d;
    end
  end

  assign load_ready_o = load_ready_q;
  assign imem_we_o    = we_q;
  assign imem_waddr_o = waddr_q;
  assign imem_wdata_o = wdata_q;
  assign cpu_resetn_o = resetn_q;
  assign halted_o     = halted_q;
  assign timeout_o    = timeout_q;
  assign load_trunc_o = trunc_q;
  assign halt_pc_o    = halt_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_sequencer.sv
// ============================================================================
// Module : tb_cpu_run_sequencer
// Brief  : Bench for cpu_run_sequencer with a tiny behavioural core and imem.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_run_sequencer;

  localparam int IW = 4;
  localparam int MC = 10;

  localparam logic [31:0] I_ADDI5  = 32'h00500513;
  localparam logic [31:0] I_INC10  = 32'h00150513;
  localparam logic [31:0] I_ECALL  = 32'h00000073;
  localparam logic [31:0] I_JLOOP  = 32'h0000006F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        run = 1'b0;
  logic        clear = 1'b0;
  logic        imem_we;
  logic [1:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_resetn;
  logic [31:0] cpu_instr;
  logic [31:0] cpu_pc;
  logic        halted;
  logic        timeout;
  logic        load_trunc;
  logic [31:0] halt_pc;
  logic [31:0] cycle_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int exp_idx  = 0;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  logic [31:0] mem [0:IW-1];
  logic [31:0] pc;
  logic [31:0] xr [0:31];

  always #5 clk = ~clk;

  cpu_run_sequencer #(.IMEM_WORDS(IW), .MAX_CYCLES(MC), .CNT_W(32)) dut (
    .clk_i(clk), .reset_i(reset), .load_valid_i(load_valid), .load_ready_o(load_ready),
    .load_data_i(load_data), .load_last_i(load_last), .run_i(run), .clear_i(clear),
    .imem_we_o(imem_we), .imem_waddr_o(imem_waddr), .imem_wdata_o(imem_wdata),
    .cpu_resetn_o(cpu_resetn), .cpu_instr_i(cpu_instr), .cpu_pc_i(cpu_pc),
    .halted_o(halted), .timeout_o(timeout), .load_trunc_o(load_trunc),
    .halt_pc_o(halt_pc), .cycle_count_o(cycle_count)
  );

  // Behavioural imem and a core subset (addi, jal, ecall stall).
  assign cpu_instr = mem[pc[3:2]];
  assign cpu_pc    = pc;

  always @(posedge clk) begin
    if (imem_we) mem[imem_waddr] <= imem_wdata;
    if (!cpu_resetn) begin
      pc <= '0;
    end else if (cpu_instr[6:0] != 7'b1110011) begin
      if (cpu_instr[6:0] == 7'b1101111) begin
        pc <= pc + {{12{cpu_instr[31]}}, cpu_instr[19:12], cpu_instr[20], cpu_instr[30:21], 1'b0};
      end else begin
        pc <= pc + 32'd4;
        if (cpu_instr[6:0] == 7'b0010011 && cpu_instr[11:7] != 5'd0)
          xr[cpu_instr[11:7]] <= xr[cpu_instr[19:15]] + {{20{cpu_instr[31]}}, cpu_instr[31:20]};
      end
    end
  end

  // Scoreboard: every imem write must match the next word the bench saw accepted.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      n_writes++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL imem_write: got write addr=%0d data=%h, required no write", imem_waddr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (imem_waddr !== mon_e.addr || imem_wdata !== mon_e.data) begin
          n_fail++;
          $display("FAIL imem_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   imem_waddr, imem_wdata, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input bit last, input int bound, output bit acc);
    load_valid = 1'b1; load_data = d; load_last = last; acc = 1'b0;
    for (int i = 0; i < bound && !acc; i++) begin
      @(negedge clk);
      if (load_ready) begin
        acc = 1'b1;
        exp_q.push_back('{addr: exp_idx[1:0], data: d});
        exp_idx++;
      end
      @(posedge clk); #1;
    end
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic start_load();
    exp_idx = 0; n_writes = 0;
    for (int i = 0; i < 32; i++) xr[i] = '0;
  endtask

  task automatic pulse_run();
    run = 1'b1; @(posedge clk); #1; run = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
  endtask

  task automatic wait_halted(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (halted) ok = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if ({load_ready, imem_we, cpu_resetn, halted, timeout, load_trunc} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, required 000000", {load_ready, imem_we, cpu_resetn, halted, timeout, load_trunc}); end
    n_checks++; if (imem_waddr !== 2'd0 || imem_wdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_imem: got addr=%0d data=%h, required 0/0", imem_waddr, imem_wdata); end
    n_checks++; if (halt_pc !== 32'd0 || cycle_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_status: got pc=%h cnt=%0d, required 0/0", halt_pc, cycle_count); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (load_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_to_load: got load_ready=%b, required 1", load_ready); end
  endtask

  task automatic test_program();
    bit acc, ok;
    logic [31:0] prog [0:3];
    prog[0] = I_ADDI5; prog[1] = I_INC10; prog[2] = I_INC10; prog[3] = I_ECALL;
    start_load();
    for (int i = 0; i < 4; i++) send_word(prog[i], (i == 3), 8, acc);
    n_checks++; if (load_ready !== 1'b0 || load_trunc !== 1'b0) begin
      n_fail++; $display("FAIL prog_loaded: got ready=%b trunc=%b, required 0/0", load_ready, load_trunc); end
    pulse_run();
    wait_halted(40, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL prog_halt: got no halt in 40 cycles, required halt"); end
    n_checks++; if (halt_pc !== 32'd12 || cycle_count !== 32'd3) begin
      n_fail++; $display("FAIL prog_result: got pc=%0d cnt=%0d, required 12/3", halt_pc, cycle_count); end
    n_checks++; if (timeout !== 1'b0 || cpu_resetn !== 1'b1) begin
      n_fail++; $display("FAIL prog_flags: got timeout=%b resetn=%b, required 0/1", timeout, cpu_resetn); end
    n_checks++; if (xr[10] !== 32'd7) begin
      n_fail++; $display("FAIL prog_x10: got %0d, required 7", xr[10]); end
    n_checks++; if (n_writes != 4 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL prog_writes: got %0d writes %0d pending, required 4/0", n_writes, exp_q.size()); end
    pulse_clear();
    n_checks++; if ({halted, timeout, cpu_resetn} !== 3'b0 || cycle_count !== 32'd0 || halt_pc !== 32'd0) begin
      n_fail++; $display("FAIL prog_clear: got h=%b t=%b rn=%b cnt=%0d pc=%h, required all 0",
                         halted, timeout, cpu_resetn, cycle_count, halt_pc); end
  endtask

  task automatic test_watchdog();
    bit acc, ok;
    start_load();
    send_word(I_JLOOP, 1'b1, 8, acc);
    pulse_run();
    wait_halted(40, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wd_halt: got no halt in 40 cycles, required halt"); end
    n_checks++; if (timeout !== 1'b1 || cpu_resetn !== 1'b0) begin
      n_fail++; $display("FAIL wd_flags: got timeout=%b resetn=%b, required 1/0", timeout, cpu_resetn); end
    n_checks++; if (cycle_count !== 32'd10 || halt_pc !== 32'd0) begin
      n_fail++; $display("FAIL wd_result: got cnt=%0d pc=%h, required 10/0", cycle_count, halt_pc); end
  endtask

  task automatic test_run_clear_together();
    run = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    run = 1'b0; clear = 1'b0;
    n_checks++; if ({halted, timeout, cpu_resetn} !== 3'b0 || cycle_count !== 32'd0 || halt_pc !== 32'd0) begin
      n_fail++; $display("FAIL runclr_idle: got h=%b t=%b rn=%b cnt=%0d pc=%h, required all 0",
                         halted, timeout, cpu_resetn, cycle_count, halt_pc); end
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (cpu_resetn !== 1'b0 || load_ready !== 1'b1) begin
      n_fail++; $display("FAIL runclr_hold: got resetn=%b ready=%b, required 0/1", cpu_resetn, load_ready); end
  endtask

  task automatic test_gaps_run_in_load();
    bit acc, ok;
    logic [31:0] prog [0:2];
    prog[0] = I_ADDI5; prog[1] = I_INC10; prog[2] = I_ECALL;
    start_load();
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_word(prog[i], (i == 2), 8, acc);
      if (i == 0) begin
        pulse_run();
        n_checks++; if (cpu_resetn !== 1'b0) begin
          n_fail++; $display("FAIL gap_run_ignored: got resetn=%b, required 0", cpu_resetn); end
      end
    end
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (cpu_resetn !== 1'b0 || load_ready !== 1'b0 || load_trunc !== 1'b0) begin
      n_fail++; $display("FAIL gap_loaded: got rn=%b ready=%b trunc=%b, required 000", cpu_resetn, load_ready, load_trunc); end
    n_checks++; if (n_writes != 3 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL gap_writes: got %0d writes %0d pending, required 3/0", n_writes, exp_q.size()); end
    pulse_run();
    wait_halted(40, ok);
    n_checks++; if (!ok || halt_pc !== 32'd8 || cycle_count !== 32'd2 || xr[10] !== 32'd6) begin
      n_fail++; $display("FAIL gap_result: got ok=%b pc=%0d cnt=%0d x10=%0d, required 1/8/2/6",
                         ok, halt_pc, cycle_count, xr[10]); end
    pulse_clear();
  endtask

  task automatic test_truncation();
    bit acc;
    int n_acc;
    start_load();
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      send_word(32'hA0 + i, 1'b0, 4, acc);
      if (acc) n_acc++;
    end
    n_checks++; if (n_acc != 4) begin
      n_fail++; $display("FAIL trunc_accepted: got %0d words, required 4", n_acc); end
    n_checks++; if (load_trunc !== 1'b1 || load_ready !== 1'b0) begin
      n_fail++; $display("FAIL trunc_flags: got trunc=%b ready=%b, required 1/0", load_trunc, load_ready); end
    n_checks++; if (n_writes != 4 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL trunc_writes: got %0d writes %0d pending, required 4/0", n_writes, exp_q.size()); end
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    n_checks++; if (load_trunc !== 1'b0) begin
      n_fail++; $display("FAIL trunc_reset: got trunc=%b, required 0", load_trunc); end
  endtask

  task automatic test_reset_in_run();
    bit acc;
    start_load();
    send_word(I_JLOOP, 1'b1, 8, acc);
    pulse_run();
    repeat (2) begin @(posedge clk); #1; end
    n_checks++; if (cycle_count !== 32'd2 || cpu_resetn !== 1'b1) begin
      n_fail++; $display("FAIL rrun_pre: got cnt=%0d rn=%b, required 2/1", cycle_count, cpu_resetn); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if ({cpu_resetn, halted, timeout, load_ready, imem_we} !== 5'b0 || cycle_count !== 32'd0 || halt_pc !== 32'd0) begin
      n_fail++; $display("FAIL rrun_idle: got flags=%b cnt=%0d pc=%h, required all 0",
                         {cpu_resetn, halted, timeout, load_ready, imem_we}, cycle_count, halt_pc); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    pc = '0;
    for (int i = 0; i < IW; i++) mem[i] = '0;
    for (int i = 0; i < 32; i++) xr[i] = '0;
    test_reset();
    test_program();
    test_watchdog();
    test_run_clear_together();
    test_gaps_run_in_load();
    test_truncation();
    test_reset_in_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, required completion");
    $fatal(1, "bench time limit exceeded");
  end

endmodule

`default_nettype wire
